// File: rtl/prefix_adder_pipe_pkg.sv
// Shared types and helpers for the pipelined parallel-prefix adder.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents: topo_e (prefix topology selector), gp_t (generate/propagate
// pair), log2_ceil (number of prefix levels), gp_op (prefix operator).
package prefix_adder_pkg;

   typedef enum logic [0:0] {
      TOPO_KS  = 1'b0,
      TOPO_SKL = 1'b1
   } topo_e;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // Number of prefix levels for a power-of-two operand width.
   function automatic int log2_ceil(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Associative (G,P) combine: hi is the more significant group.
   function automatic gp_t gp_op(input gp_t hi, input gp_t lo);
      gp_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage

// File: rtl/prefix_adder_pipe_if.sv
// Operand/result bus of the pipelined prefix adder.
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready on both the operand and the result side.
//
// Signals: in_valid/in_ready/a/b/cin/sub (operand beat), out_valid/out_ready/
// sum/cout (result beat); ovf/zero exist only with PREFIX_ADDER_FLAGS_EN.
// master = upstream/downstream environment, slave = the adder.
interface prefix_adder_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef PREFIX_ADDER_FLAGS_EN
   logic             ovf;
   logic             zero;
`endif

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout
`ifdef PREFIX_ADDER_FLAGS_EN
      , input ovf, zero
`endif
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout
`ifdef PREFIX_ADDER_FLAGS_EN
      , output ovf, zero
`endif
   );

endinterface

// File: rtl/prefix_adder_pipe_prefix_level.sv
// One combinational prefix level (Kogge-Stone or Sklansky) at distance 2^K.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline owns all flow control.
//
// Ports: gp_in  - (G,P) pairs entering level K
//        gp_out - (G,P) pairs leaving level K; untouched positions pass through
module prefix_level
   import prefix_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TOPO  = 0,
   parameter int K     = 0
) (
   input  gp_t [WIDTH-1:0] gp_in,
   output wire gp_t [WIDTH-1:0] gp_out
);

   localparam int SPAN = 1 << K;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (TOPO == int'(TOPO_SKL)) begin : g_skl
         if (((i >> K) & 1) == 1) begin : g_op
            // Top bit of the lower half of the enclosing 2^(K+1) block.
            localparam int J = ((i >> (K + 1)) << (K + 1)) + SPAN - 1;
            assign gp_out[i] = gp_op(gp_in[i], gp_in[J]);
         end else begin : g_pass
            assign gp_out[i] = gp_in[i];
         end
      end else begin : g_ks
         if (i >= SPAN) begin : g_op
            assign gp_out[i] = gp_op(gp_in[i], gp_in[i-SPAN]);
         end else begin : g_pass
            assign gp_out[i] = gp_in[i];
         end
      end
   end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined parallel-prefix adder/subtractor, power-of-two WIDTH, KS or Sklansky.
// Latency: PIPE=1 -> log2(WIDTH)+2 cycles, PIPE=0 -> 1 cycle; 1 beat/cycle.
// Backpressure: one global enable (!out_valid || out_ready) freezes every stage.
//
// Ports: clk, rst_n (async active-low), bus (prefix_adder_pipe_if.slave):
//   in_valid/in_ready/a/b/cin/sub in, out_valid/out_ready/sum/cout out.
// Optional: PREFIX_ADDER_FLAGS_EN adds ovf (signed overflow) and zero flags.
module prefix_adder_pipe
   import prefix_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TOPO  = 0,
   parameter int PIPE  = 1
) (
   input logic                clk,
   input logic                rst_n,
   prefix_adder_pipe_if.slave bus
);

   localparam int L = log2_ceil(WIDTH);

   logic out_vld_reg;
   logic en;

   // Bubbles are kept, so the whole pipe moves in lockstep.
   assign en           = !out_vld_reg || bus.out_ready;
   assign bus.in_ready = en;

   // ---------------- operand preparation / pre-processing ----------------
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] pre_g;
   logic [WIDTH-1:0] pre_p;
   logic             c0;
   gp_t  [WIDTH-1:0] pre_gp;

   always_comb begin
      b_eff = bus.b ^ {WIDTH{bus.sub}};
      c0    = bus.cin ^ bus.sub;
      pre_p = bus.a ^ b_eff;
      pre_g = bus.a & b_eff;
      // Folding the carry-in into bit 0 makes every G[i] a true carry out.
      pre_g[0] = pre_g[0] | (pre_p[0] & c0);
      for (int i = 0; i < WIDTH; i++) begin
         pre_gp[i].g = pre_g[i];
         pre_gp[i].p = pre_p[i];
      end
   end

   // ---------------- prefix network ----------------
   // Stage s feeds level s; stage L holds the finished carries.
   gp_t  [WIDTH-1:0] stg_gp  [L+1];
   logic [WIDTH-1:0] stg_p   [L+1];
   logic             stg_c0  [L+1];
   logic             stg_vld [L+1];
   wire gp_t [WIDTH-1:0] lvl_gp [L];

   for (genvar k = 0; k < L; k++) begin : g_lvl
      prefix_level #(
         .WIDTH (WIDTH),
         .TOPO  (TOPO),
         .K     (k)
      ) u_level (
         .gp_in  (stg_gp[k]),
         .gp_out (lvl_gp[k])
      );
   end

   if (PIPE != 0) begin : g_pipe
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int s = 0; s <= L; s++) begin
               stg_gp[s]  <= '0;
               stg_p[s]   <= '0;
               stg_c0[s]  <= 1'b0;
               stg_vld[s] <= 1'b0;
            end
         end else if (en) begin
            stg_gp[0]  <= pre_gp;
            stg_p[0]   <= pre_p;
            stg_c0[0]  <= c0;
            stg_vld[0] <= bus.in_valid && en;
            for (int s = 1; s <= L; s++) begin
               stg_gp[s]  <= lvl_gp[s-1];
               stg_p[s]   <= stg_p[s-1];
               stg_c0[s]  <= stg_c0[s-1];
               stg_vld[s] <= stg_vld[s-1];
            end
         end
      end
   end else begin : g_comb
      always_comb begin
         stg_gp[0]  = pre_gp;
         stg_p[0]   = pre_p;
         stg_c0[0]  = c0;
         stg_vld[0] = bus.in_valid && en;
         for (int s = 1; s <= L; s++) begin
            stg_gp[s]  = lvl_gp[s-1];
            stg_p[s]   = stg_p[s-1];
            stg_c0[s]  = stg_c0[s-1];
            stg_vld[s] = stg_vld[s-1];
         end
      end
   end

   // ---------------- post-processing and output register ----------------
   logic [WIDTH-1:0] sum_nxt;
   logic             cout_nxt;

   always_comb begin
      sum_nxt    = '0;
      sum_nxt[0] = stg_p[L][0] ^ stg_c0[L];
      for (int i = 1; i < WIDTH; i++) begin
         sum_nxt[i] = stg_p[L][i] ^ stg_gp[L][i-1].g;
      end
      cout_nxt = stg_gp[L][WIDTH-1].g;
   end

   // Group-propagate bits of the last stage carry no information forward.
   logic unused_gp_p;
   always_comb begin
      unused_gp_p = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         unused_gp_p = unused_gp_p ^ stg_gp[L][i].p;
      end
   end

   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg;
`ifdef PREFIX_ADDER_FLAGS_EN
   logic             ovf_reg;
   logic             zero_reg;
   logic             ovf_nxt;
   // Signed overflow: carry into the MSB differs from carry out of it.
   assign ovf_nxt = stg_gp[L][WIDTH-2].g ^ stg_gp[L][WIDTH-1].g;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_reg <= 1'b0;
         sum_reg     <= '0;
         cout_reg    <= 1'b0;
`ifdef PREFIX_ADDER_FLAGS_EN
         ovf_reg     <= 1'b0;
         zero_reg    <= 1'b0;
`endif
      end else if (en) begin
         out_vld_reg <= stg_vld[L];
         sum_reg     <= sum_nxt;
         cout_reg    <= cout_nxt;
`ifdef PREFIX_ADDER_FLAGS_EN
         ovf_reg     <= ovf_nxt;
         zero_reg    <= (sum_nxt == '0);
`endif
      end
   end

   assign bus.out_valid = out_vld_reg;
   assign bus.sum       = sum_reg;
   assign bus.cout      = cout_reg;
`ifdef PREFIX_ADDER_FLAGS_EN
   assign bus.ovf       = ovf_reg;
   assign bus.zero      = zero_reg;
`endif

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed and randomized checks of prefix_adder_pipe in four configurations.
// dut0: W=8 KS PIPE=1, dut1: W=32 SKL PIPE=1, dut2: W=64 KS PIPE=0,
// dut3: W=16 SKL PIPE=0. Flag checks only when PREFIX_ADDER_FLAGS_EN is set.
module tb_prefix_adder_pipe;

   localparam int NDUT = 4;
   localparam int WID [NDUT] = '{8, 32, 64, 16};
   localparam int LAT [NDUT] = '{5, 7, 1, 1};

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic        drv_vld  [NDUT];
   logic [63:0] drv_a    [NDUT];
   logic [63:0] drv_b    [NDUT];
   logic        drv_cin  [NDUT];
   logic        drv_sub  [NDUT];
   logic        drv_ordy [NDUT];
   logic        mon_rdy  [NDUT];
   logic        mon_vld  [NDUT];
   logic [63:0] mon_sum  [NDUT];
   logic        mon_cout [NDUT];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   prefix_adder_pipe_if #(.WIDTH(8))  if0 ();
   prefix_adder_pipe_if #(.WIDTH(32)) if1 ();
   prefix_adder_pipe_if #(.WIDTH(64)) if2 ();
   prefix_adder_pipe_if #(.WIDTH(16)) if3 ();

   prefix_adder_pipe #(.WIDTH(8),  .TOPO(0), .PIPE(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   prefix_adder_pipe #(.WIDTH(32), .TOPO(1), .PIPE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   prefix_adder_pipe #(.WIDTH(64), .TOPO(0), .PIPE(0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
   prefix_adder_pipe #(.WIDTH(16), .TOPO(1), .PIPE(0)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

   assign if0.in_valid = drv_vld[0];  assign if0.a = drv_a[0][7:0];
   assign if0.b = drv_b[0][7:0];      assign if0.cin = drv_cin[0];
   assign if0.sub = drv_sub[0];       assign if0.out_ready = drv_ordy[0];
   assign if1.in_valid = drv_vld[1];  assign if1.a = drv_a[1][31:0];
   assign if1.b = drv_b[1][31:0];     assign if1.cin = drv_cin[1];
   assign if1.sub = drv_sub[1];       assign if1.out_ready = drv_ordy[1];
   assign if2.in_valid = drv_vld[2];  assign if2.a = drv_a[2];
   assign if2.b = drv_b[2];           assign if2.cin = drv_cin[2];
   assign if2.sub = drv_sub[2];       assign if2.out_ready = drv_ordy[2];
   assign if3.in_valid = drv_vld[3];  assign if3.a = drv_a[3][15:0];
   assign if3.b = drv_b[3][15:0];     assign if3.cin = drv_cin[3];
   assign if3.sub = drv_sub[3];       assign if3.out_ready = drv_ordy[3];

   always_comb begin
      mon_rdy[0] = if0.in_ready; mon_vld[0] = if0.out_valid;
      mon_sum[0] = {56'd0, if0.sum}; mon_cout[0] = if0.cout;
      mon_rdy[1] = if1.in_ready; mon_vld[1] = if1.out_valid;
      mon_sum[1] = {32'd0, if1.sum}; mon_cout[1] = if1.cout;
      mon_rdy[2] = if2.in_ready; mon_vld[2] = if2.out_valid;
      mon_sum[2] = if2.sum; mon_cout[2] = if2.cout;
      mon_rdy[3] = if3.in_ready; mon_vld[3] = if3.out_valid;
      mon_sum[3] = {48'd0, if3.sum}; mon_cout[3] = if3.cout;
   end

   typedef struct {
      int          d;
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic        sub;
      logic [63:0] s;
      logic        c;
   } vec_t;

   // Reference arithmetic: returns {cout, sum} with sum masked to w bits.
   function automatic logic [64:0] model_add(input int w, input logic [63:0] a,
                                             input logic [63:0] b, input logic cin,
                                             input logic sub);
      logic [64:0] mask;
      logic [64:0] be;
      logic [64:0] r;
      mask = (65'd1 << w) - 65'd1;
      be   = sub ? ((~{1'b0, b}) & mask) : ({1'b0, b} & mask);
      r    = ({1'b0, a} & mask) + be + {64'd0, cin ^ sub};
      return {r[w], r[63:0] & mask[63:0]};
   endfunction

   task automatic idle_all();
      for (int d = 0; d < NDUT; d++) begin
         drv_vld[d]  = 1'b0;
         drv_a[d]    = '0;
         drv_b[d]    = '0;
         drv_cin[d]  = 1'b0;
         drv_sub[d]  = 1'b0;
         drv_ordy[d] = 1'b1;
      end
   endtask

   task automatic test_reset();
      idle_all();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         total++;
         if (mon_vld[d] !== 1'b0) begin bad++; $display("FAIL reset_out_valid d%0d: got %b need 0", d, mon_vld[d]); end
         total++;
         if (mon_sum[d] !== 64'd0) begin bad++; $display("FAIL reset_sum d%0d: got %h need 0", d, mon_sum[d]); end
         total++;
         if (mon_cout[d] !== 1'b0) begin bad++; $display("FAIL reset_cout d%0d: got %b need 0", d, mon_cout[d]); end
         total++;
         if (mon_rdy[d] !== 1'b1) begin bad++; $display("FAIL reset_in_ready d%0d: got %b need 1", d, mon_rdy[d]); end
      end
   endtask

   task automatic test_add_sub();
      vec_t vt [13];
      int   d;
      int   lat;
      logic got;
      vt[0]  = '{0, 64'hFF, 64'h01, 1'b0, 1'b0, 64'h00, 1'b1};
      vt[1]  = '{0, 64'h05, 64'h07, 1'b0, 1'b1, 64'hFE, 1'b0};
      vt[2]  = '{0, 64'h07, 64'h07, 1'b0, 1'b1, 64'h00, 1'b1};
      vt[3]  = '{0, 64'h10, 64'h03, 1'b1, 1'b1, 64'h0C, 1'b1};
      vt[4]  = '{0, 64'h3A, 64'h45, 1'b1, 1'b0, 64'h80, 1'b0};
      vt[5]  = '{1, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1};
      vt[6]  = '{1, 64'h1234_5678, 64'h9ABC_DEF0, 1'b0, 1'b0, 64'hACF1_3568, 1'b0};
      vt[7]  = '{1, 64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF, 1'b0};
      vt[8]  = '{2, 64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vt[9]  = '{2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1};
      vt[10] = '{3, 64'h8000, 64'h8000, 1'b0, 1'b0, 64'h0, 1'b1};
      vt[11] = '{3, 64'h1234, 64'h1234, 1'b0, 1'b1, 64'h0, 1'b1};
      vt[12] = '{3, 64'h00FF, 64'h0001, 1'b1, 1'b0, 64'h0101, 1'b0};
      for (int v = 0; v < 13; v++) begin
         idle_all();
         repeat (3) @(posedge clk);
         #1;
         d = vt[v].d;
         drv_a[d]   = vt[v].a;
         drv_b[d]   = vt[v].b;
         drv_cin[d] = vt[v].cin;
         drv_sub[d] = vt[v].sub;
         drv_vld[d] = 1'b1;
         @(negedge clk);
         total++;
         if (mon_rdy[d] !== 1'b1) begin bad++; $display("FAIL vec%0d_in_ready: got %b need 1", v, mon_rdy[d]); end
         lat = 0;
         got = 1'b0;
         while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            drv_vld[d] = 1'b0;
            lat++;
            if (mon_vld[d] === 1'b1) got = 1'b1;
         end
         total++;
         if (lat !== LAT[d]) begin bad++; $display("FAIL vec%0d_latency: got %0d need %0d", v, lat, LAT[d]); end
         total++;
         if (mon_sum[d] !== vt[v].s) begin bad++; $display("FAIL vec%0d_sum: got %h need %h", v, mon_sum[d], vt[v].s); end
         total++;
         if (mon_cout[d] !== vt[v].c) begin bad++; $display("FAIL vec%0d_cout: got %b need %b", v, mon_cout[d], vt[v].c); end
      end
   endtask

   task automatic test_stall();
      int idx;
      int stall;
      int cyc;
      int k;
      int extra;
      idle_all();
      repeat (8) @(posedge clk);
      #1;
      drv_ordy[0] = 1'b0;
      idx = 0; stall = 0; cyc = 0;
      // Fill the pipe with out_ready low, then sit stalled for 3 cycles.
      while (stall < 3 && cyc < 30) begin
         drv_vld[0] = (idx < 6);
         drv_a[0]   = 64'h10 + 64'(idx);
         drv_b[0]   = 64'h20;
         @(negedge clk);
         if (mon_rdy[0] === 1'b1) begin
            if (drv_vld[0]) idx++;
         end else begin
            stall++;
            total++;
            if (mon_vld[0] !== 1'b1) begin bad++; $display("FAIL stall_out_valid: got %b need 1", mon_vld[0]); end
            total++;
            if (mon_sum[0] !== 64'h30) begin bad++; $display("FAIL stall_sum: got %h need 30", mon_sum[0]); end
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      total++;
      if (stall !== 3) begin bad++; $display("FAIL stall_reached: got %0d stalled cycles need 3", stall); end
      total++;
      if (idx !== 5) begin bad++; $display("FAIL stall_accepted: got %0d beats need 5", idx); end
      drv_ordy[0] = 1'b1;
      k = 0; cyc = 0;
      while (k < 6 && cyc < 40) begin
         drv_vld[0] = (idx < 6);
         drv_a[0]   = 64'h10 + 64'(idx);
         @(negedge clk);
         if (mon_vld[0] === 1'b1) begin
            total++;
            if (mon_sum[0] !== 64'h30 + 64'(k)) begin
               bad++; $display("FAIL stall_drain_beat%0d: got %h need %h", k, mon_sum[0], 64'h30 + 64'(k));
            end
            k++;
         end
         if (drv_vld[0] && mon_rdy[0] === 1'b1) idx++;
         @(posedge clk);
         #1;
         cyc++;
      end
      drv_vld[0] = 1'b0;
      total++;
      if (k !== 6) begin bad++; $display("FAIL stall_drain_count: got %0d need 6", k); end
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (mon_vld[0] !== 1'b0) extra++;
      end
      total++;
      if (extra !== 0) begin bad++; $display("FAIL stall_duplicate: got %0d extra beats need 0", extra); end
   endtask

   task automatic test_reset_mid();
      int extra;
      idle_all();
      repeat (8) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         drv_vld[0] = 1'b1;
         drv_a[0]   = 64'h40 + 64'(i);
         drv_b[0]   = 64'h01;
         @(posedge clk);
         #1;
      end
      drv_vld[0] = 1'b0;
      total++;
      if (mon_vld[0] !== 1'b1 || mon_sum[0] !== 64'h41) begin
         bad++; $display("FAIL rstmid_before: got v=%b s=%h need v=1 s=41", mon_vld[0], mon_sum[0]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (mon_vld[0] !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b need 0", mon_vld[0]); end
      total++;
      if (mon_sum[0] !== 64'd0) begin bad++; $display("FAIL rstmid_sum: got %h need 0", mon_sum[0]); end
      total++;
      if (mon_cout[0] !== 1'b0) begin bad++; $display("FAIL rstmid_cout: got %b need 0", mon_cout[0]); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (mon_rdy[0] !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b need 1", mon_rdy[0]); end
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (mon_vld[0] !== 1'b0) extra++;
      end
      total++;
      if (extra !== 0) begin bad++; $display("FAIL rstmid_stale: got %0d stale beats need 0", extra); end
   endtask

`ifdef PREFIX_ADDER_FLAGS_EN
   task automatic test_flags();
      logic [7:0] fa [2];
      logic [7:0] fs [2];
      logic       fc [2];
      logic       fz [2];
      fa[0] = 8'h7F; fs[0] = 8'h80; fc[0] = 1'b0; fz[0] = 1'b0;
      fa[1] = 8'h80; fs[1] = 8'h00; fc[1] = 1'b1; fz[1] = 1'b1;
      for (int v = 0; v < 2; v++) begin
         idle_all();
         repeat (8) @(posedge clk);
         #1;
         drv_a[0]   = {56'd0, fa[v]};
         drv_b[0]   = (v == 0) ? 64'h01 : 64'h80;
         drv_vld[0] = 1'b1;
         @(posedge clk);
         #1;
         drv_vld[0] = 1'b0;
         repeat (4) @(posedge clk);
         #1;
         total++;
         if (mon_vld[0] !== 1'b1 || mon_sum[0][7:0] !== fs[v] || mon_cout[0] !== fc[v]) begin
            bad++; $display("FAIL flags%0d_result: got v=%b s=%h c=%b need v=1 s=%h c=%b",
                            v, mon_vld[0], mon_sum[0], mon_cout[0], fs[v], fc[v]);
         end
         total++;
         if (if0.ovf !== 1'b1) begin bad++; $display("FAIL flags%0d_ovf: got %b need 1", v, if0.ovf); end
         total++;
         if (if0.zero !== fz[v]) begin bad++; $display("FAIL flags%0d_zero: got %b need %b", v, if0.zero, fz[v]); end
      end
   endtask
`endif

   task automatic test_random(input int d, input int nbeats);
      logic [64:0] mask;
      logic [64:0] q [$];
      logic [64:0] exp_v;
      logic [64:0] got_v;
      logic        took;
      int          sent;
      int          rcvd;
      int          cyc;
      idle_all();
      repeat (8) @(posedge clk);
      #1;
      mask = (65'd1 << WID[d]) - 65'd1;
      sent = 0; rcvd = 0; cyc = 0; took = 1'b0;
      while (rcvd < nbeats && cyc < nbeats * 8) begin
         // A presented beat that was not taken must be held unchanged.
         if (!drv_vld[d] || took) begin
            if (sent < nbeats && $urandom_range(0, 3) != 0) begin
               drv_a[d]   = {$urandom, $urandom} & mask[63:0];
               drv_b[d]   = {$urandom, $urandom} & mask[63:0];
               case ($urandom_range(0, 7))
                  0: drv_a[d] = mask[63:0];
                  1: drv_b[d] = drv_a[d];
                  2: drv_b[d] = 64'd1;
                  default: ;
               endcase
               drv_cin[d] = 1'($urandom_range(0, 1));
               drv_sub[d] = 1'($urandom_range(0, 1));
               drv_vld[d] = 1'b1;
            end else begin
               drv_vld[d] = 1'b0;
            end
         end
         drv_ordy[d] = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (mon_vld[d] === 1'b1 && drv_ordy[d]) begin
            got_v = {mon_cout[d], mon_sum[d]};
            total++;
            if (q.size() == 0) begin
               bad++; $display("FAIL rand_d%0d_unexpected: got %h with nothing outstanding", d, got_v);
            end else begin
               exp_v = q.pop_front();
               if (got_v !== exp_v) begin
                  bad++; $display("FAIL rand_d%0d_beat%0d: got %h need %h", d, rcvd, got_v, exp_v);
               end
            end
            rcvd++;
         end
         took = drv_vld[d] && (mon_rdy[d] === 1'b1);
         if (took) begin
            q.push_back(model_add(WID[d], drv_a[d], drv_b[d], drv_cin[d], drv_sub[d]));
            sent++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      drv_vld[d]  = 1'b0;
      drv_ordy[d] = 1'b1;
      total++;
      if (rcvd !== nbeats || q.size() != 0) begin
         bad++; $display("FAIL rand_d%0d_count: got %0d results need %0d", d, rcvd, nbeats);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle_all();
      test_reset();
      test_add_sub();
      test_stall();
      test_reset_mid();
`ifdef PREFIX_ADDER_FLAGS_EN
      test_flags();
`endif
      for (int d = 0; d < NDUT; d++) test_random(d, 2500);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
